// File: rtl/draw_text_pages.sv
// Menu / text-page overlay drawn as a scaled character window; key codes and colours mirror vga_pkg.
// Optional `define CURSOR_BLINK_EN makes the menu highlight blink with a ~64-frame period.

module draw_text_pages #(
   parameter int unsigned NUM_PAGES       = 4,
   parameter int unsigned POS_X           = 230,
   parameter int unsigned POS_Y           = 200,
   parameter int unsigned COLS            = 64,
   parameter int unsigned ROWS            = 4,
   parameter int unsigned MENU_SCALE      = 2,
   parameter int unsigned PAGE_SCALE      = 0,
   parameter int unsigned FONT_LAT        = 2,
   parameter logic [11:0] MENU_TEXT_COLOR = 12'hfff,
   parameter logic [11:0] MENU_BG_COLOR   = 12'h00a,
   parameter logic [11:0] TEXT1_COLOR     = 12'h0f0,
   parameter logic [11:0] TEXT1_BG_COLOR  = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  key_i,
   input  logic [10:0] in_hcount_i,
   input  logic        in_hsync_i,
   input  logic        in_hblnk_i,
   input  logic [10:0] in_vcount_i,
   input  logic        in_vsync_i,
   input  logic        in_vblnk_i,
   input  logic [11:0] in_rgb_i,
   input  logic [7:0]  char_line_pixels_i,
   output logic [10:0] out_hcount_o,
   output logic        out_hsync_o,
   output logic        out_hblnk_o,
   output logic [10:0] out_vcount_o,
   output logic        out_vsync_o,
   output logic        out_vblnk_o,
   output logic [11:0] out_rgb_o,
   output logic [8:0]  char_xy_o,
   output logic [3:0]  char_line_o,
   output logic [2:0]  page_sel_o,
   output logic [2:0]  cursor_o
);

   localparam logic [3:0] KeyUp    = 4'd8;
   localparam logic [3:0] KeyDown  = 4'd9;
   localparam logic [3:0] KeyEnter = 4'd10;
   localparam logic [3:0] KeyEsc   = 4'd11;
   localparam logic [2:0] LastPage = 3'(NUM_PAGES);

   typedef struct packed {
      logic        hsync;
      logic        hblnk;
      logic        vsync;
      logic        vblnk;
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic [11:0] rgb;
      logic        win;
      logic        menu;
      logic        hl;
      logic [2:0]  bitidx;
   } pix_t;

   logic [3:0] key_prev_q;
   logic       vblnk_prev_q;
   logic [2:0] page_q, pending_q, cursor_q;
   logic       key_evt, vblnk_rise, hl_en;

   assign key_evt    = (key_i != key_prev_q) && (key_i != 4'd0);
   assign vblnk_rise = in_vblnk_i && !vblnk_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_prev_q   <= '0;
         vblnk_prev_q <= 1'b0;
         page_q       <= '0;
         pending_q    <= '0;
         cursor_q     <= 3'd1;
      end else begin
         key_prev_q   <= key_i;
         vblnk_prev_q <= in_vblnk_i;
         // page switches only at frame boundaries so a frame never tears
         if (vblnk_rise) page_q <= pending_q;
         if (key_evt) begin
            if (page_q == 3'd0) begin
               case (key_i)
                  KeyUp:    cursor_q  <= (cursor_q == 3'd1) ? LastPage : cursor_q - 3'd1;
                  KeyDown:  cursor_q  <= (cursor_q == LastPage) ? 3'd1 : cursor_q + 3'd1;
                  KeyEnter: pending_q <= cursor_q;
                  default:  if ({28'd0, key_i} <= NUM_PAGES) pending_q <= key_i[2:0];
               endcase
            end else if (key_i == KeyEsc) begin
               pending_q <= 3'd0;
            end
         end
      end
   end

`ifdef CURSOR_BLINK_EN
   logic [5:0] blink_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) blink_q <= '0;
      else if (vblnk_rise) blink_q <= blink_q + 6'd1;
   end
   assign hl_en = ~blink_q[5];
`else
   assign hl_en = 1'b1;
`endif

   // Stage 1: window decode from the raw counters.
   logic        menu, in_win;
   logic [10:0] hoff, voff, col_full, row_full;
   pix_t        st1_d;

   assign menu     = (page_q == 3'd0);
   assign hoff     = in_hcount_i - 11'(POS_X);
   assign voff     = in_vcount_i - 11'(POS_Y);
   assign col_full = menu ? (hoff >> (3 + MENU_SCALE)) : (hoff >> (3 + PAGE_SCALE));
   assign row_full = menu ? (voff >> (4 + MENU_SCALE)) : (voff >> (4 + PAGE_SCALE));
   assign in_win   = !in_hblnk_i && !in_vblnk_i
                   && (in_hcount_i >= 11'(POS_X)) && (in_vcount_i >= 11'(POS_Y))
                   && (col_full < 11'(COLS)) && (row_full < 11'(ROWS));

   always_comb begin
      st1_d        = '0;
      st1_d.hsync  = in_hsync_i;
      st1_d.hblnk  = in_hblnk_i;
      st1_d.vsync  = in_vsync_i;
      st1_d.vblnk  = in_vblnk_i;
      st1_d.hcount = in_hcount_i;
      st1_d.vcount = in_vcount_i;
      st1_d.rgb    = in_rgb_i;
      st1_d.win    = in_win;
      st1_d.menu   = menu;
      st1_d.hl     = menu && hl_en && (({1'b0, row_full[2:0]} + 4'd1) == {1'b0, cursor_q});
      st1_d.bitidx = 3'd7 - (menu ? hoff[MENU_SCALE +: 3] : hoff[PAGE_SCALE +: 3]);
   end

   pix_t       pipe_q [0:FONT_LAT];
   logic [8:0] char_xy_q;
   logic [3:0] char_line_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= FONT_LAT; i++) pipe_q[i] <= '0;
         char_xy_q   <= '0;
         char_line_q <= '0;
      end else begin
         pipe_q[0] <= st1_d;
         for (int i = 1; i <= FONT_LAT; i++) pipe_q[i] <= pipe_q[i-1];
         char_xy_q   <= in_win ? {row_full[2:0], col_full[5:0]} : 9'd0;
         char_line_q <= in_win ? (menu ? voff[MENU_SCALE +: 4] : voff[PAGE_SCALE +: 4]) : 4'd0;
      end
   end

   // Pixel stage: the last pipe entry lines up with the font row for its character.
   pix_t        last;
   logic [11:0] fg, bg, rgb_d;

   assign last = pipe_q[FONT_LAT];

   always_comb begin
      fg = last.menu ? MENU_TEXT_COLOR : TEXT1_COLOR;
      bg = last.menu ? MENU_BG_COLOR   : TEXT1_BG_COLOR;
      if (last.hl) begin
         fg = last.menu ? MENU_BG_COLOR   : TEXT1_BG_COLOR;
         bg = last.menu ? MENU_TEXT_COLOR : TEXT1_COLOR;
      end
      rgb_d = last.win ? (char_line_pixels_i[last.bitidx] ? fg : bg) : last.rgb;
   end

   logic [10:0] out_hcount_q, out_vcount_q;
   logic        out_hsync_q, out_hblnk_q, out_vsync_q, out_vblnk_q;
   logic [11:0] out_rgb_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_hcount_q <= '0;
         out_vcount_q <= '0;
         out_hsync_q  <= 1'b0;
         out_hblnk_q  <= 1'b0;
         out_vsync_q  <= 1'b0;
         out_vblnk_q  <= 1'b0;
         out_rgb_q    <= '0;
      end else begin
         out_hcount_q <= last.hcount;
         out_vcount_q <= last.vcount;
         out_hsync_q  <= last.hsync;
         out_hblnk_q  <= last.hblnk;
         out_vsync_q  <= last.vsync;
         out_vblnk_q  <= last.vblnk;
         out_rgb_q    <= rgb_d;
      end
   end

   assign out_hcount_o = out_hcount_q;
   assign out_vcount_o = out_vcount_q;
   assign out_hsync_o  = out_hsync_q;
   assign out_hblnk_o  = out_hblnk_q;
   assign out_vsync_o  = out_vsync_q;
   assign out_vblnk_o  = out_vblnk_q;
   assign out_rgb_o    = out_rgb_q;
   assign char_xy_o    = char_xy_q;
   assign char_line_o  = char_line_q;
   assign page_sel_o   = page_q;
   assign cursor_o     = cursor_q;

endmodule

// File: tb/tb_draw_text_pages.sv
// Bench for draw_text_pages: directed key/pixel scenarios plus random traffic against an
// arithmetic reference model of the menu, page switching and character window.

module tb_draw_text_pages;

   localparam int NP   = 4;
   localparam int PX   = 230;
   localparam int PY   = 200;
   localparam int COLS = 64;
   localparam int ROWS = 4;
   localparam int MS   = 2;
   localparam int PS   = 0;
   localparam int HMAX = 8192;
   localparam logic [11:0] C_MT = 12'hfff;
   localparam logic [11:0] C_MB = 12'h00a;
   localparam logic [11:0] C_TT = 12'h0f0;
   localparam logic [11:0] C_TB = 12'h000;
   localparam logic [3:0]  K_UP = 4'd8;
   localparam logic [3:0]  K_DN = 4'd9;
   localparam logic [3:0]  K_ENT = 4'd10;
   localparam logic [3:0]  K_ESC = 4'd11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  key = '0;
   logic [10:0] hc = '0, vc = '0;
   logic        hs = 1'b0, hb = 1'b0, vs = 1'b0, vb = 1'b0;
   logic [11:0] rgb = '0;
   logic [7:0]  pix = '0;
   logic [10:0] o_hc, o_vc;
   logic        o_hs, o_hb, o_vs, o_vb;
   logic [11:0] o_rgb;
   logic [8:0]  o_xy;
   logic [3:0]  o_cl;
   logic [2:0]  o_page, o_cur;

   draw_text_pages #(
      .NUM_PAGES(NP), .POS_X(PX), .POS_Y(PY), .COLS(COLS), .ROWS(ROWS),
      .MENU_SCALE(MS), .PAGE_SCALE(PS), .FONT_LAT(2),
      .MENU_TEXT_COLOR(C_MT), .MENU_BG_COLOR(C_MB), .TEXT1_COLOR(C_TT), .TEXT1_BG_COLOR(C_TB)
   ) dut (
      .clk(clk), .rst(rst), .key_i(key),
      .in_hcount_i(hc), .in_hsync_i(hs), .in_hblnk_i(hb),
      .in_vcount_i(vc), .in_vsync_i(vs), .in_vblnk_i(vb), .in_rgb_i(rgb),
      .char_line_pixels_i(pix),
      .out_hcount_o(o_hc), .out_hsync_o(o_hs), .out_hblnk_o(o_hb),
      .out_vcount_o(o_vc), .out_vsync_o(o_vs), .out_vblnk_o(o_vb), .out_rgb_o(o_rgb),
      .char_xy_o(o_xy), .char_line_o(o_cl), .page_sel_o(o_page), .cursor_o(o_cur)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n        = 0;
   int base     = 0;
   bit skip_wait = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, n);
      end
   endtask

   // staged stimulus for the next cycle
   logic [3:0]  s_key = '0;
   logic [10:0] s_hc = '0, s_vc = '0;
   logic        s_hs = 1'b0, s_hb = 1'b0, s_vs = 1'b0, s_vb = 1'b0;
   logic [11:0] s_rgb = '0;
   logic [7:0]  s_pix = '0;

   // reference model state: register contents during the current cycle
   int m_page, m_cursor, m_pending, m_kprev, m_blink;
   bit m_vprev;

   logic [25:0] r_tim [HMAX];
   logic [11:0] r_rgb [HMAX];
   logic [11:0] r_fg  [HMAX];
   logic [11:0] r_bg  [HMAX];
   bit          r_win [HMAX];
   int          r_bit [HMAX];
   logic [12:0] r_xyl [HMAX];
   logic [7:0]  r_pix [HMAX];

   task automatic model_reset();
      m_page = 0; m_cursor = 1; m_pending = 0; m_kprev = 0; m_blink = 0; m_vprev = 1'b0;
   endtask

   task automatic step();
      int hoff, voff, s, col, row, np;
      bit menu, win, ev, blink_ok;
      logic [11:0] exp_rgb, fg, bg;
      if (!skip_wait) @(negedge clk);
      skip_wait = 1'b0;
      if (n >= HMAX) begin
         $display("FAIL history_budget: got %0d cycles, limit %0d", n, HMAX);
         $fatal(1, "history exhausted");
      end
      if (n >= base + 4) begin
         check_eq("out_timing", {o_hs, o_hb, o_vs, o_vb, o_hc, o_vc}, r_tim[n-4]);
         exp_rgb = r_win[n-4] ? (r_pix[n-1][r_bit[n-4]] ? r_fg[n-4] : r_bg[n-4]) : r_rgb[n-4];
         check_eq("out_rgb", o_rgb, exp_rgb);
      end else begin
         check_eq("out_flushed", {o_hs, o_hb, o_vs, o_vb, o_hc, o_vc, o_rgb}, 64'd0);
      end
      if (n >= base + 1) check_eq("char_xy_line", {o_xy, o_cl}, r_xyl[n-1]);
      else               check_eq("char_xy_line0", {o_xy, o_cl}, 64'd0);
      check_eq("page_sel", o_page, m_page);
      check_eq("cursor", o_cur, m_cursor);

      menu = (m_page == 0);
      s    = menu ? MS : PS;
      hoff = int'(s_hc) - PX;
      voff = int'(s_vc) - PY;
      win  = !s_hb && !s_vb && hoff >= 0 && voff >= 0;
      col  = win ? hoff / (8 << s) : 0;
      row  = win ? voff / (16 << s) : 0;
      win  = win && col < COLS && row < ROWS;
`ifdef CURSOR_BLINK_EN
      blink_ok = (m_blink < 32);
`else
      blink_ok = 1'b1;
`endif
      fg = menu ? C_MT : C_TT;
      bg = menu ? C_MB : C_TB;
      if (menu && win && blink_ok && (row + 1 == m_cursor)) begin
         fg = C_MB;
         bg = C_MT;
      end
      r_win[n] = win;
      r_bit[n] = win ? 7 - ((hoff / (1 << s)) % 8) : 0;
      r_xyl[n] = win ? {9'(row * 64 + col), 4'((voff / (1 << s)) % 16)} : 13'd0;
      r_fg[n]  = fg;
      r_bg[n]  = bg;
      r_tim[n] = {s_hs, s_hb, s_vs, s_vb, s_hc, s_vc};
      r_rgb[n] = s_rgb;
      r_pix[n] = s_pix;

      ev = (int'(s_key) != m_kprev) && (s_key != 4'd0);
      np = (s_vb && !m_vprev) ? m_pending : m_page;
      if (ev) begin
         if (m_page == 0) begin
            if (s_key == K_UP)       m_cursor = (m_cursor == 1) ? NP : m_cursor - 1;
            else if (s_key == K_DN)  m_cursor = (m_cursor == NP) ? 1 : m_cursor + 1;
            else if (s_key == K_ENT) m_pending = m_cursor;
            else if (int'(s_key) <= NP) m_pending = int'(s_key);
         end else if (s_key == K_ESC) begin
            m_pending = 0;
         end
      end
      if (s_vb && !m_vprev) m_blink = (m_blink + 1) % 64;
      m_page  = np;
      m_kprev = int'(s_key);
      m_vprev = s_vb;

      key = s_key; hc = s_hc; vc = s_vc; hs = s_hs; hb = s_hb; vs = s_vs; vb = s_vb;
      rgb = s_rgb; pix = s_pix;
      n++;
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic do_reset();
      if (!skip_wait) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("rst_out", {o_hs, o_hb, o_vs, o_vb, o_hc, o_vc, o_rgb}, 64'd0);
      check_eq("rst_char", {o_xy, o_cl}, 64'd0);
      check_eq("rst_page", o_page, 64'd0);
      check_eq("rst_cursor", o_cur, 64'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base = n;
      model_reset();
      skip_wait = 1'b1;
   endtask

   task automatic press(input logic [3:0] k);
      s_key = k; run(3);
      s_key = 4'd0; run(3);
   endtask

   task automatic frame_edge();
      s_vb = 1'b1; run(3);
      s_vb = 1'b0; run(3);
   endtask

   task automatic px_check(input string tag, input int x, input int y, input logic [7:0] p,
                           input logic [11:0] exp);
      s_hc = 11'(x); s_vc = 11'(y); s_pix = p; s_rgb = 12'h5a5; s_hb = 1'b0; s_vb = 1'b0;
      run(6);
      check_eq(tag, o_rgb, exp);
   endtask

   function automatic logic [3:0] pick_key();
      case ($urandom_range(0, 6))
         0:       return 4'd0;
         1:       return K_UP;
         2:       return K_DN;
         3:       return K_ENT;
         4:       return K_ESC;
         5:       return 4'($urandom_range(12, 15));
         default: return 4'($urandom_range(1, 7));
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL timeout: got no finish, expected finish within 1 ms");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      do_reset();
      s_hc = 11'd100; s_vc = 11'd100;
      s_key = K_DN; run(100);
      s_key = 4'd0; run(2);
      check_eq("held_down_once", o_cur, 64'd2);
      press(K_UP);
      press(K_UP);
      check_eq("up_wraps", o_cur, 64'd4);

      s_hc = 11'd400; s_vc = 11'd300;
      press(4'd3);
      run(10);
      check_eq("page_waits_vblnk", o_page, 64'd0);
      frame_edge();
      check_eq("page_after_vblnk", o_page, 64'd3);
      px_check("page_px_fg", PX, PY, 8'h80, C_TT);
      px_check("page_px_scale0", PX + 1, PY, 8'h80, C_TB);

      press(K_ESC);
      press(4'd2);
      frame_edge();
      check_eq("esc_then_2", o_page, 64'd0);

      press(K_DN);
      press(K_DN);
      check_eq("cursor_to_2", o_cur, 64'd2);
      px_check("menu_hl_row", PX, PY + 64, 8'h80, C_MB);
      px_check("menu_row0", PX, PY, 8'h80, C_MT);
      px_check("left_of_window", PX - 1, PY, 8'h80, 12'h5a5);

      press(4'd7);
      frame_edge();
      check_eq("key7_ignored", o_page, 64'd0);
      press(K_ENT);
      frame_edge();
      check_eq("enter_page2", o_page, 64'd2);

      s_hc = 11'(PX + 5); s_vc = 11'(PY + 3); s_rgb = 12'h3c3; s_pix = 8'hff;
      run(5);
      do_reset();

      for (int i = 0; i < 4000; i++) begin
         s_hc  = 11'($urandom_range(150, 1000));
         s_vc  = 11'($urandom_range(150, 480));
         s_hb  = ($urandom_range(0, 9) == 0);
         s_vb  = ((i % 80) >= 70);
         s_hs  = 1'($urandom);
         s_vs  = 1'($urandom);
         s_rgb = 12'($urandom);
         s_pix = 8'($urandom);
         if ($urandom_range(0, 9) == 0) s_key = pick_key();
         if (i == 2000) do_reset();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
